core_regwrite_arbiter: RTL and testbench
========================================

Name: core_regwrite_arbiter

Overview:
Shares the single register-file write port (addr_write/data_write/write_enable) between three writeback sources: interrupt/context unit, memory-load return and ALU writeback. Applies fixed priority with anti-starvation aging. Keeps a pending-load scoreboard so decode can stall on read-after-load hazards. Sits between the execute/memory stages and the register file, one instance per core.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a requester may wait with valid high before forced top priority (range 1..15)
NUM_GP, 11, count of writable general-purpose registers (addresses 0..NUM_GP-1)
PC_ADDR, 11, register address of the program counter

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
irq_valid  input  1  interrupt/context unit write request
irq_addr  input  4  target register
irq_data  input  16  write data
irq_ready  output  1  irq request accepted this cycle
mem_valid  input  1  load-return write request
mem_addr  input  4  target register
mem_data  input  16  load data
mem_ready  output  1  mem request accepted this cycle
alu_valid  input  1  ALU writeback request
alu_addr  input  4  target register
alu_data  input  16  result
alu_ready  output  1  ALU request accepted this cycle
pend_set  input  1  decode issued a load; mark pend_addr pending
pend_addr  input  4  load destination register
chk_addr_a  input  4  decode source operand A
chk_addr_b  input  4  decode source operand B
rf_addr_write  output  4  to register file addr_write
rf_data_write  output  16  to register file data_write
rf_write_enable  output  1  to register file write_enable
hazard  output  1  a checked source is pending
pc_write_pending  output  1  PC write issued; fetch must hold pc_inc

Behaviour:
- Reset (rst_n low, async): rf_write_enable=0, rf_addr_write=0, rf_data_write=0; all readies 0; scoreboard cleared; all age counters 0; hazard=0; pc_write_pending=0. Reset mid-transfer discards the in-flight write; no rf write occurs in the release cycle.
- Handshake: requester holds valid/addr/data stable until ready. Transfer = valid & ready. Exactly one ready high per cycle at most. Ready is combinational from valids and age counters.
- Arbitration: default priority irq > mem > alu. Per-requester 4-bit age counter: increments when valid & !ready, saturates at 15, clears on transfer or when valid low. Any requester with age >= STARVE_LIMIT is promoted above all non-promoted requesters. Ties among promoted requesters use the default order.
- Output: one-cycle registered latency. Transfer in cycle N drives rf_write_enable=1 with the captured addr/data in cycle N+1. Otherwise rf_write_enable=0 and addr/data hold their last value. Back-to-back transfers give a write every cycle.
- Addresses 12..15 (read-only constants/bus): request is accepted, rf_write_enable stays 0, and no scoreboard effect.
- Address PC_ADDR: pc_write_pending=1 in the same cycle as rf_write_enable (N+1), so fetch suppresses pc_inc and the register file's write-over-increment rule holds. pc_write_pending returns to 0 in N+2 unless another PC write follows.
- Scoreboard: 16-bit pending vector. pend_set sets bit pend_addr at the clock edge (ignored for addr >= NUM_GP and PC_ADDR). A mem transfer clears bit mem_addr at the transfer edge. If set and clear hit the same address in the same cycle, set wins (new load outstanding). irq/alu writes do not clear bits.
- hazard = pending[chk_addr_a] | pending[chk_addr_b] (combinational). It also asserts when a checked address equals the captured target while rf_write_enable is high; bypass does not exist.

Decomposition:
- Shared package core_pkg: REG_PC=11, REG_ZERO=12, REG_ONE=13, REG_ALLONES=14, REG_BUS=15, NUM_GP=11; typedef wb_req_t {valid, addr[3:0], data[15:0]}; enum wb_src_e {SRC_IRQ, SRC_MEM, SRC_ALU}.
- Sub-module core_wb_age_counter: one per requester (4-bit saturating counter with promote flag). The priority select and scoreboard stay in the top module.

Test Plan:
- Reset: drive all valids high with rst_n low -> all readies 0, rf_write_enable 0. Release -> irq_ready=1 first cycle; write to irq_addr appears next cycle.
- Simultaneous irq(addr 2, 0x1111), mem(addr 3, 0x2222), alu(addr 4, 0x3333) -> rf writes in consecutive cycles in order 2/0x1111, 3/0x2222, 4/0x3333.
- Starvation: irq and mem valid continuously with fresh data, alu(addr 5) valid, STARVE_LIMIT=4 -> alu_ready asserts in the 5th cycle of waiting; its write appears the next cycle.
- Scoreboard: pend_set addr 6, then chk_addr_a=6 -> hazard=1. mem transfer to 6 -> hazard=0 the cycle after the edge. pend_set 6 together with mem transfer to 6 -> hazard stays 1.
- PC: alu write addr 11 data 0x0040 -> rf_write_enable=1, rf_addr_write=11 and pc_write_pending=1 in the same cycle, then pc_write_pending=0.
- Constant target: mem write addr 13 -> mem_ready=1, rf_write_enable stays 0, scoreboard unchanged. Assert rst_n low during the cycle after an accepted write -> rf_write_enable drops to 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core writeback path: special register addresses,
// the writeback request bundle and the source ordering used for priority.
package core_pkg;

   localparam logic [3:0] REG_PC      = 4'd11;
   localparam logic [3:0] REG_ZERO    = 4'd12;
   localparam logic [3:0] REG_ONE     = 4'd13;
   localparam logic [3:0] REG_ALLONES = 4'd14;
   localparam logic [3:0] REG_BUS     = 4'd15;
   localparam int         NUM_GP      = 11;
   localparam int         NUM_SRC     = 3;

   typedef struct packed {
      logic        valid;
      logic [3:0]  addr;
      logic [15:0] data;
   } wb_req_t;

   // Enum order is also the default priority order (lowest value wins).
   typedef enum logic [1:0] {
      SRC_IRQ = 2'd0,
      SRC_MEM = 2'd1,
      SRC_ALU = 2'd2
   } wb_src_e;

endpackage

// File: rtl/core_wb_age_counter.sv
// Per-requester wait-age tracker: counts cycles spent waiting with valid high
// and flags the requester for promotion once it has waited STARVE_LIMIT cycles.
module core_wb_age_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic valid_i,
   input  logic ready_i,
   output logic promote_o
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] age_q, age_d;

   always_comb begin
      age_d = age_q;
      if (!valid_i || ready_i) begin
         age_d = 4'd0;
      end else if (age_q != 4'hF) begin
         age_d = age_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= 4'd0;
      end else begin
         age_q <= age_d;
      end
   end

   assign promote_o = valid_i && (age_q >= LIMIT);

endmodule

// File: rtl/core_regwrite_arbiter.sv
// Arbitrates the single register-file write port between irq, load-return and
// ALU writeback, and tracks outstanding loads so decode can stall on hazards.
module core_regwrite_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int NUM_GP       = 11,
   parameter int PC_ADDR      = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        irq_valid,
   input  logic [3:0]  irq_addr,
   input  logic [15:0] irq_data,
   output logic        irq_ready,
   input  logic        mem_valid,
   input  logic [3:0]  mem_addr,
   input  logic [15:0] mem_data,
   output logic        mem_ready,
   input  logic        alu_valid,
   input  logic [3:0]  alu_addr,
   input  logic [15:0] alu_data,
   output logic        alu_ready,
   input  logic        pend_set,
   input  logic [3:0]  pend_addr,
   input  logic [3:0]  chk_addr_a,
   input  logic [3:0]  chk_addr_b,
   output logic [3:0]  rf_addr_write,
   output logic [15:0] rf_data_write,
   output logic        rf_write_enable,
   output logic        hazard,
   output logic        pc_write_pending
);

   import core_pkg::*;

   localparam logic [3:0] PC_A = 4'(PC_ADDR);

   wb_req_t              req [NUM_SRC];
   wb_req_t              sel_req;
   logic [NUM_SRC-1:0]   valid, promote, cand, grant;
   logic                 xfer, writable;

   logic                 we_q, we_d;
   logic [3:0]           addr_q, addr_d;
   logic [15:0]          data_q, data_d;
   logic                 pcp_q, pcp_d;
   logic [15:0]          pend_q, pend_d;

   assign req[SRC_IRQ] = {irq_valid, irq_addr, irq_data};
   assign req[SRC_MEM] = {mem_valid, mem_addr, mem_data};
   assign req[SRC_ALU] = {alu_valid, alu_addr, alu_data};

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_age
         assign valid[gi] = req[gi].valid;
         core_wb_age_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_age (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_i  (valid[gi]),
            .ready_i  (grant[gi]),
            .promote_o(promote[gi])
         );
      end
   endgenerate

   // Promoted requesters mask everyone else; lowest set bit is highest priority.
   always_comb begin
      cand  = (|promote) ? promote : valid;
      grant = cand & ~(cand - NUM_SRC'(1));
      if (!rst_n) begin
         grant = '0;
      end
   end

   always_comb begin
      sel_req = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            sel_req = req[i];
         end
      end
   end

   assign xfer     = |grant;
   assign writable = (int'(sel_req.addr) < NUM_GP) || (sel_req.addr == PC_A);

   always_comb begin
      we_d   = xfer && writable;
      addr_d = addr_q;
      data_d = data_q;
      pcp_d  = xfer && (sel_req.addr == PC_A);
      if (xfer && writable) begin
         addr_d = sel_req.addr;
         data_d = sel_req.data;
      end
      // Set is applied after clear so a fresh load to the same register wins.
      pend_d = pend_q;
      if (grant[SRC_MEM]) begin
         pend_d[mem_addr] = 1'b0;
      end
      if (pend_set && (int'(pend_addr) < NUM_GP) && (pend_addr != PC_A)) begin
         pend_d[pend_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         addr_q <= 4'd0;
         data_q <= 16'd0;
         pcp_q  <= 1'b0;
         pend_q <= 16'd0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         pcp_q  <= pcp_d;
         pend_q <= pend_d;
      end
   end

   assign irq_ready        = grant[SRC_IRQ];
   assign mem_ready        = grant[SRC_MEM];
   assign alu_ready        = grant[SRC_ALU];
   assign rf_write_enable  = we_q;
   assign rf_addr_write    = addr_q;
   assign rf_data_write    = data_q;
   assign pc_write_pending = pcp_q;

   // No bypass: a register being written this cycle still counts as a hazard.
   assign hazard = pend_q[chk_addr_a] | pend_q[chk_addr_b] |
                   (we_q && ((chk_addr_a == addr_q) || (chk_addr_b == addr_q)));

endmodule

// File: tb/tb_core_regwrite_arbiter.sv
// Directed and randomized checks of the writeback arbiter against a
// cycle-level behavioural model of priority, aging, scoreboard and outputs.
module tb_core_regwrite_arbiter;

   localparam int LIMIT = 4;
   localparam int NGP   = 11;
   localparam int PC    = 11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v [3];
   logic [3:0]  ad [3];
   logic [15:0] dt [3];
   logic        pend_set;
   logic [3:0]  pend_addr, chk_a, chk_b;
   logic        irq_ready, mem_ready, alu_ready;
   logic [3:0]  rf_addr_write;
   logic [15:0] rf_data_write;
   logic        rf_write_enable, hazard, pc_write_pending;

   int          m_age [3];
   bit          m_pend [16];
   logic        m_we, m_pcp;
   logic [3:0]  m_addr;
   logic [15:0] m_data;
   bit          refill [3];
   int          last_g;
   int          checks = 0;
   int          errors = 0;
   int          first_alu;

   always #5 clk = ~clk;

   core_regwrite_arbiter #(.STARVE_LIMIT(LIMIT), .NUM_GP(NGP), .PC_ADDR(PC)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .irq_valid       (v[0]),
      .irq_addr        (ad[0]),
      .irq_data        (dt[0]),
      .irq_ready       (irq_ready),
      .mem_valid       (v[1]),
      .mem_addr        (ad[1]),
      .mem_data        (dt[1]),
      .mem_ready       (mem_ready),
      .alu_valid       (v[2]),
      .alu_addr        (ad[2]),
      .alu_data        (dt[2]),
      .alu_ready       (alu_ready),
      .pend_set        (pend_set),
      .pend_addr       (pend_addr),
      .chk_addr_a      (chk_a),
      .chk_addr_b      (chk_b),
      .rf_addr_write   (rf_addr_write),
      .rf_data_write   (rf_data_write),
      .rf_write_enable (rf_write_enable),
      .hazard          (hazard),
      .pc_write_pending(pc_write_pending)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_age[i] = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      m_we = 1'b0; m_pcp = 1'b0; m_addr = 4'd0; m_data = 16'd0;
   endtask

   // Starved requesters first in irq/mem/alu order, otherwise plain irq/mem/alu order.
   function automatic int pick();
      int w = -1;
      for (int i = 0; i < 3; i++) if (w < 0 && v[i] && m_age[i] >= LIMIT) w = i;
      for (int i = 0; i < 3; i++) if (w < 0 && v[i]) w = i;
      return w;
   endfunction

   task automatic cycle();
      int          g;
      logic [2:0]  eg;
      logic        eh;
      logic [3:0]  a;
      @(negedge clk);
      g  = pick();
      eg = (g < 0) ? 3'b000 : 3'(1 << g);
      eh = m_pend[chk_a] | m_pend[chk_b] | (m_we && (chk_a == m_addr || chk_b == m_addr));
      chk("ready", 16'({alu_ready, mem_ready, irq_ready}), 16'(eg));
      chk("we", 16'(rf_write_enable), 16'(m_we));
      chk("addr", 16'(rf_addr_write), 16'(m_addr));
      chk("data", rf_data_write, m_data);
      chk("hazard", 16'(hazard), 16'(eh));
      chk("pc_pending", 16'(pc_write_pending), 16'(m_pcp));
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (v[i] && i != g) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
         else                m_age[i] = 0;
      end
      if (g >= 0) begin
         a     = ad[g];
         m_we  = (int'(a) < NGP) || (int'(a) == PC);
         m_pcp = (int'(a) == PC);
         if (m_we) begin
            m_addr = a;
            m_data = dt[g];
         end
      end else begin
         m_we  = 1'b0;
         m_pcp = 1'b0;
      end
      if (g == 1) m_pend[ad[1]] = 1'b0;
      if (pend_set && int'(pend_addr) < NGP && int'(pend_addr) != PC) m_pend[pend_addr] = 1'b1;
      last_g = g;
      #1;
      if (g >= 0) begin
         if (refill[g]) begin
            ad[g] = 4'($urandom);
            dt[g] = 16'($urandom);
         end else begin
            v[g] = 1'b0;
         end
      end
      pend_set = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      v[0] = 1'b1; ad[0] = 4'd2; dt[0] = 16'h1111;
      v[1] = 1'b1; ad[1] = 4'd3; dt[1] = 16'h2222;
      v[2] = 1'b1; ad[2] = 4'd4; dt[2] = 16'h3333;
      pend_set = 1'b0; pend_addr = 4'd0; chk_a = 4'd0; chk_b = 4'd0;
      for (int i = 0; i < 3; i++) refill[i] = 1'b0;
      model_reset();

      // Reset holds every ready low even with all requests pending.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 16'({alu_ready, mem_ready, irq_ready}), 16'd0);
      chk("rst_we", 16'(rf_write_enable), 16'd0);
      chk("rst_addr", 16'(rf_addr_write), 16'd0);
      chk("rst_data", rf_data_write, 16'd0);
      chk("rst_hazard", 16'(hazard), 16'd0);
      chk("rst_pcp", 16'(pc_write_pending), 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Simultaneous requests drain in default priority order.
      cycle(); chk("order1_addr", 16'(rf_addr_write), 16'd2); chk("order1_data", rf_data_write, 16'h1111);
      cycle(); chk("order2_addr", 16'(rf_addr_write), 16'd3); chk("order2_data", rf_data_write, 16'h2222);
      cycle(); chk("order3_addr", 16'(rf_addr_write), 16'd4); chk("order3_data", rf_data_write, 16'h3333);
      cycle();

      // Starvation: irq always valid, alu must win on its 5th waiting cycle.
      v[0] = 1'b1; ad[0] = 4'd1; dt[0] = 16'h0101; refill[0] = 1'b1;
      v[2] = 1'b1; ad[2] = 4'd5; dt[2] = 16'h5555;
      first_alu = -1;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (last_g == 2 && first_alu < 0) begin
            first_alu = k;
            chk("starve_wr_addr", 16'(rf_addr_write), 16'd5);
            chk("starve_wr_data", rf_data_write, 16'h5555);
         end
      end
      chk("starve_cycle", 16'(first_alu), 16'd5);
      refill[0] = 1'b0; v[0] = 1'b0;
      cycle();

      // Scoreboard set, clear by load return, and set-wins collision.
      chk_a = 4'd6; chk_b = 4'd0;
      pend_set = 1'b1; pend_addr = 4'd6;
      cycle(); chk("hazard_set", 16'(hazard), 16'd1);
      v[1] = 1'b1; ad[1] = 4'd6; dt[1] = 16'h6666;
      cycle(); cycle(); chk("hazard_clear", 16'(hazard), 16'd0);
      v[1] = 1'b1; ad[1] = 4'd6; dt[1] = 16'h7777;
      pend_set = 1'b1; pend_addr = 4'd6;
      cycle(); cycle(); chk("hazard_set_wins", 16'(hazard), 16'd1);
      v[1] = 1'b1; ad[1] = 4'd6; dt[1] = 16'h8888;
      cycle(); cycle();

      // PC write raises pc_write_pending alongside the write strobe.
      chk_a = 4'd0;
      v[2] = 1'b1; ad[2] = 4'd11; dt[2] = 16'h0040;
      cycle();
      chk("pc_we", 16'(rf_write_enable), 16'd1);
      chk("pc_addr", 16'(rf_addr_write), 16'd11);
      chk("pc_pend_hi", 16'(pc_write_pending), 16'd1);
      cycle();
      chk("pc_pend_lo", 16'(pc_write_pending), 16'd0);

      // Constant target is accepted but never written.
      v[1] = 1'b1; ad[1] = 4'd13; dt[1] = 16'hBEEF;
      cycle();
      chk("const_we", 16'(rf_write_enable), 16'd0);
      chk("const_hold_addr", 16'(rf_addr_write), 16'd11);
      cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            refill[i] = 1'($urandom_range(0, 1));
            if (!v[i] && $urandom_range(0, 1) == 1) begin
               v[i]  = 1'b1;
               ad[i] = 4'($urandom);
               dt[i] = 16'($urandom);
            end
         end
         chk_a     = 4'($urandom);
         chk_b     = 4'($urandom);
         pend_set  = ($urandom_range(0, 2) == 0);
         pend_addr = 4'($urandom);
         cycle();
      end
      for (int i = 0; i < 3; i++) begin
         refill[i] = 1'b0;
         v[i]      = 1'b0;
      end
      cycle();

      // Reset in the cycle after an accepted write kills the strobe at once.
      chk_a = 4'd0; chk_b = 4'd0;
      v[2] = 1'b1; ad[2] = 4'd3; dt[2] = 16'hABCD;
      cycle();
      chk("mid_we_before", 16'(rf_write_enable), 16'd1);
      v[0] = 1'b1; ad[0] = 4'd2; dt[0] = 16'h4242;
      rst_n = 1'b0;
      #1;
      chk("mid_we_after", 16'(rf_write_enable), 16'd0);
      chk("mid_ready", 16'(irq_ready), 16'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle();
      chk("post_rst_addr", 16'(rf_addr_write), 16'd2);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
